// File: rtl/cpu_pkg.sv
// Shared CPU pipeline definitions: load-op encodings, default widths and
// helpers that derive the inter-stage bus widths.
package cpu_pkg;

  localparam int XLEN_DEF   = 32;
  localparam int REG_AW_DEF = 5;

  typedef enum logic [2:0] {
    LD_B  = 3'b000,
    LD_H  = 3'b001,
    LD_W  = 3'b010,
    LD_D  = 3'b011,
    LD_BU = 3'b100,
    LD_HU = 3'b101,
    LD_WU = 3'b110
  } load_op_e;

  function automatic int ex_bus_width(input int xlen, input int reg_aw);
    return 6 + reg_aw + 2 * xlen;
  endfunction

  function automatic int wb_bus_width(input int xlen, input int reg_aw);
    return 1 + reg_aw + 2 * xlen;
  endfunction

endpackage

// File: rtl/load_align.sv
// Selects the addressed byte/half/word/double from a load response and
// sign- or zero-extends it to the full datapath width.
module load_align
  import cpu_pkg::*;
#(
  parameter int XLEN  = XLEN_DEF,
  localparam int OFF_W = $clog2(XLEN / 8)
) (
  input  logic [XLEN-1:0]  data,
  input  logic [OFF_W-1:0] offset,
  input  logic [2:0]       load_op,
  output logic [XLEN-1:0]  result
);

  logic [XLEN-1:0] shifted;

  function automatic logic [XLEN-1:0] ext(input logic [XLEN-1:0] v, input int nbits,
                                          input logic sgn);
    logic [XLEN-1:0] r;
    logic            fill;
    fill = sgn & v[nbits-1];
    for (int i = 0; i < XLEN; i++) begin
      r[i] = (i < nbits) ? v[i] : fill;
    end
    return r;
  endfunction

  // Doublewords ignore the offset; unsupported ops pass the raw word through
  always_comb begin
    shifted = data >> {offset, 3'b000};
    result  = data;
    case (load_op)
      LD_B:    result = ext(shifted, 8, 1'b1);
      LD_H:    result = ext(shifted, 16, 1'b1);
      LD_BU:   result = ext(shifted, 8, 1'b0);
      LD_HU:   result = ext(shifted, 16, 1'b0);
      LD_W: begin
        if (XLEN == 64) result = ext(shifted, 32, 1'b1);
        else            result = data;
      end
      LD_WU: begin
        if (XLEN == 64) result = ext(shifted, 32, 1'b0);
        else            result = data;
      end
      LD_D:    result = data;
      default: result = data;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: holds loads until data_ok, aligns returned data, drops
// responses orphaned by a flush and exports forwarding/stall info to ID.
module mem_stage
  import cpu_pkg::*;
#(
  parameter int XLEN     = XLEN_DEF,
  parameter int REG_AW   = REG_AW_DEF,
  parameter int EX_BUS_W = ex_bus_width(XLEN, REG_AW),
  parameter int WB_BUS_W = wb_bus_width(XLEN, REG_AW)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                flush,
  input  logic                ex_to_mem_valid,
  input  logic [EX_BUS_W-1:0] ex_to_mem_bus,
  output logic                mem_allowin,
  input  logic                data_sram_data_ok,
  input  logic [XLEN-1:0]     data_sram_rdata,
  input  logic                wb_allowin,
  output logic                mem_to_wb_valid,
  output logic [WB_BUS_W-1:0] mem_to_wb_bus,
  output logic                fwd_we,
  output logic [REG_AW-1:0]   fwd_dest,
  output logic [XLEN-1:0]     fwd_data,
  output logic                fwd_stall
);

  localparam int OFF_W = $clog2(XLEN / 8);

  logic                mem_valid_q, mem_valid_d;
  logic [EX_BUS_W-1:0] bus_q, bus_d;
  logic [XLEN-1:0]     rdata_buf_q, rdata_buf_d;
  logic                data_got_q, data_got_d;
  logic                discard_q, discard_d;

  logic              mem_req, res_from_mem, gr_we;
  logic [2:0]        load_op;
  logic [REG_AW-1:0] dest;
  logic [XLEN-1:0]   alu_result, pc, load_data, extracted, final_result;
  logic              in_wait, ready_go;

  assign pc           = bus_q[XLEN-1:0];
  assign alu_result   = bus_q[2*XLEN-1:XLEN];
  assign dest         = bus_q[2*XLEN+REG_AW-1:2*XLEN];
  assign gr_we        = bus_q[2*XLEN+REG_AW];
  assign load_op      = bus_q[2*XLEN+REG_AW+3:2*XLEN+REG_AW+1];
  assign res_from_mem = bus_q[2*XLEN+REG_AW+4];
  assign mem_req      = bus_q[2*XLEN+REG_AW+5];

  assign in_wait   = mem_valid_q && mem_req && !data_got_q;
  assign ready_go  = !mem_req || data_got_q || (data_sram_data_ok && !discard_q);
  assign load_data = data_got_q ? rdata_buf_q : data_sram_rdata;

  load_align #(.XLEN(XLEN)) u_load_align (
    .data    (load_data),
    .offset  (alu_result[OFF_W-1:0]),
    .load_op (load_op),
    .result  (extracted)
  );

  assign final_result    = res_from_mem ? extracted : alu_result;
  assign mem_allowin     = !mem_valid_q || (ready_go && wb_allowin);
  assign mem_to_wb_valid = mem_valid_q && ready_go && !flush;
  assign mem_to_wb_bus   = {gr_we, dest, final_result, pc};
  assign fwd_we          = mem_valid_q && gr_we && (dest != '0);
  assign fwd_dest        = dest;
  assign fwd_data        = final_result;
  assign fwd_stall       = in_wait;

  // A response arriving while WB is blocked is parked so it is not requested twice
  always_comb begin
    mem_valid_d = mem_valid_q;
    bus_d       = bus_q;
    rdata_buf_d = rdata_buf_q;
    data_got_d  = data_got_q;
    discard_d   = discard_q;
    if (flush) begin
      mem_valid_d = 1'b0;
      data_got_d  = 1'b0;
    end else if (mem_allowin) begin
      mem_valid_d = ex_to_mem_valid;
      data_got_d  = 1'b0;
      if (ex_to_mem_valid) begin
        bus_d = ex_to_mem_bus;
      end else begin
        bus_d = bus_q;
      end
    end else if (in_wait && data_sram_data_ok && !discard_q) begin
      rdata_buf_d = data_sram_rdata;
      data_got_d  = 1'b1;
    end else begin
      mem_valid_d = mem_valid_q;
    end

    if (data_sram_data_ok && discard_q) begin
      discard_d = 1'b0;
    end else if (flush && in_wait && !data_sram_data_ok) begin
      discard_d = 1'b1;
    end else begin
      discard_d = discard_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mem_valid_q <= 1'b0;
      data_got_q  <= 1'b0;
      discard_q   <= 1'b0;
    end else begin
      mem_valid_q <= mem_valid_d;
      data_got_q  <= data_got_d;
      discard_q   <= discard_d;
    end
  end

  always_ff @(posedge clk) begin
    bus_q       <= bus_d;
    rdata_buf_q <= rdata_buf_d;
  end

endmodule

// File: tb/tb_mem_stage.sv
// Directed self-checking bench for mem_stage: a 32-bit instance for handshake,
// flush and reset behaviour, plus a 64-bit instance for LD/LW/LWU extraction.
module tb_mem_stage;
  import cpu_pkg::*;

  localparam int AW    = 5;
  localparam int EXW32 = 6 + AW + 64;
  localparam int WBW32 = 1 + AW + 64;
  localparam int EXW64 = 6 + AW + 128;
  localparam int WBW64 = 1 + AW + 128;

  logic clk = 1'b0;
  logic reset, flush, wb_allowin;

  logic             ex_valid, allowin, data_ok, wb_valid, fwd_we, fwd_stall;
  logic [EXW32-1:0] ex_bus;
  logic [31:0]      rdata, fwd_data;
  logic [WBW32-1:0] wb_bus;
  logic [AW-1:0]    fwd_dest;

  logic             ex64_valid, allowin64, data_ok64, wb_valid64, fwd_we64, fwd_stall64;
  logic [EXW64-1:0] ex64_bus;
  logic [63:0]      rdata64, fwd_data64;
  logic [WBW64-1:0] wb64_bus;
  logic [AW-1:0]    fwd_dest64;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mem_stage u_dut (
    .clk(clk), .reset(reset), .flush(flush),
    .ex_to_mem_valid(ex_valid), .ex_to_mem_bus(ex_bus), .mem_allowin(allowin),
    .data_sram_data_ok(data_ok), .data_sram_rdata(rdata), .wb_allowin(wb_allowin),
    .mem_to_wb_valid(wb_valid), .mem_to_wb_bus(wb_bus),
    .fwd_we(fwd_we), .fwd_dest(fwd_dest), .fwd_data(fwd_data), .fwd_stall(fwd_stall)
  );

  mem_stage #(.XLEN(64)) u_dut64 (
    .clk(clk), .reset(reset), .flush(flush),
    .ex_to_mem_valid(ex64_valid), .ex_to_mem_bus(ex64_bus), .mem_allowin(allowin64),
    .data_sram_data_ok(data_ok64), .data_sram_rdata(rdata64), .wb_allowin(wb_allowin),
    .mem_to_wb_valid(wb_valid64), .mem_to_wb_bus(wb64_bus),
    .fwd_we(fwd_we64), .fwd_dest(fwd_dest64), .fwd_data(fwd_data64), .fwd_stall(fwd_stall64)
  );

  function automatic logic [EXW32-1:0] bus32(input logic req, input logic rfm,
      input logic [2:0] op, input logic we, input logic [4:0] dst,
      input logic [31:0] alu, input logic [31:0] pc);
    return {req, rfm, op, we, dst, alu, pc};
  endfunction

  function automatic logic [EXW64-1:0] bus64(input logic [2:0] op, input logic [4:0] dst,
      input logic [63:0] alu, input logic [63:0] pc);
    return {1'b1, 1'b1, op, 1'b1, dst, alu, pc};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; wb_allowin = 1'b1;
    ex_valid = 1'b0; ex_bus = '0; data_ok = 1'b0; rdata = 32'h0;
    ex64_valid = 1'b0; ex64_bus = '0; data_ok64 = 1'b0; rdata64 = 64'h0;
    tick(); tick();
    settle();
    chk("rst_allowin", allowin, 1'b1);
    chk("rst_wb_valid", wb_valid, 1'b0);
    chk("rst_fwd_we", fwd_we, 1'b0);
    chk("rst_fwd_stall", fwd_stall, 1'b0);
    reset = 1'b0;
    tick();

    // Non-load, single cycle in MEM
    ex_valid = 1'b1; ex_bus = bus32(1'b0, 1'b0, 3'b000, 1'b1, 5'd5, 32'h0000_1234, 32'h1000_0000);
    settle();
    chk("alu_allowin", allowin, 1'b1);
    tick();
    ex_valid = 1'b0; settle();
    chk("alu_valid", wb_valid, 1'b1);
    chk("alu_bus", wb_bus, {1'b1, 5'd5, 32'h0000_1234, 32'h1000_0000});
    chk("alu_fwd_we", fwd_we, 1'b1);
    chk("alu_fwd_dest", fwd_dest, 5'd5);
    chk("alu_fwd_data", fwd_data, 32'h0000_1234);
    chk("alu_fwd_stall", fwd_stall, 1'b0);
    tick();
    chk("alu_drained", wb_valid, 1'b0);

    // Write to r0 is never forwarded
    ex_valid = 1'b1; ex_bus = bus32(1'b0, 1'b0, 3'b000, 1'b1, 5'd0, 32'h0000_0077, 32'h1000_0004);
    tick();
    ex_valid = 1'b0; settle();
    chk("r0_fwd_we", fwd_we, 1'b0);
    tick();

    // LB offset 3, data_ok 3 cycles late
    ex_valid = 1'b1; ex_bus = bus32(1'b1, 1'b1, LD_B, 1'b1, 5'd6, 32'h0000_1003, 32'h1000_0008);
    tick();
    ex_valid = 1'b0; settle();
    chk("lb_stall1", fwd_stall, 1'b1);
    chk("lb_wait_valid", wb_valid, 1'b0);
    chk("lb_wait_allowin", allowin, 1'b0);
    tick();
    chk("lb_stall2", fwd_stall, 1'b1);
    tick();
    chk("lb_stall3", fwd_stall, 1'b1);
    tick();
    data_ok = 1'b1; rdata = 32'h80FF_FFFF; settle();
    chk("lb_valid", wb_valid, 1'b1);
    chk("lb_result", wb_bus[63:32], 32'hFFFF_FF80);
    chk("lb_allowin", allowin, 1'b1);
    ex_valid = 1'b1; ex_bus = bus32(1'b1, 1'b1, LD_BU, 1'b1, 5'd6, 32'h0000_1003, 32'h1000_000C);
    tick();
    ex_valid = 1'b0; data_ok = 1'b1; rdata = 32'h80FF_FFFF; settle();
    chk("lbu_valid", wb_valid, 1'b1);
    chk("lbu_result", wb_bus[63:32], 32'h0000_0080);
    tick();
    data_ok = 1'b0; settle();
    chk("lbu_drained", wb_valid, 1'b0);

    // LH offset 2 with WB blocked: response buffered
    ex_valid = 1'b1; ex_bus = bus32(1'b1, 1'b1, LD_H, 1'b1, 5'd9, 32'h0000_2002, 32'h1000_0010);
    tick();
    ex_valid = 1'b0; wb_allowin = 1'b0; data_ok = 1'b1; rdata = 32'h80FF_1234; settle();
    chk("lh_valid", wb_valid, 1'b1);
    chk("lh_allowin_blk", allowin, 1'b0);
    chk("lh_result", wb_bus[63:32], 32'hFFFF_80FF);
    tick();
    data_ok = 1'b0; rdata = 32'h0; settle();
    chk("lh_buf_valid", wb_valid, 1'b1);
    chk("lh_buf_result", wb_bus[63:32], 32'hFFFF_80FF);
    chk("lh_buf_stall", fwd_stall, 1'b0);
    chk("lh_buf_allowin", allowin, 1'b0);
    tick();
    wb_allowin = 1'b1; settle();
    chk("lh_rel_valid", wb_valid, 1'b1);
    chk("lh_rel_result", wb_bus[63:32], 32'hFFFF_80FF);
    chk("lh_rel_allowin", allowin, 1'b1);
    tick();
    chk("lh_drained", wb_valid, 1'b0);

    // Flush in WAIT: the orphaned response is dropped
    ex_valid = 1'b1; ex_bus = bus32(1'b1, 1'b1, LD_W, 1'b1, 5'd7, 32'h0000_3000, 32'h1000_0014);
    tick();
    ex_valid = 1'b0; flush = 1'b1; settle();
    chk("fl_valid", wb_valid, 1'b0);
    tick();
    flush = 1'b0;
    ex_valid = 1'b1; ex_bus = bus32(1'b1, 1'b1, LD_W, 1'b1, 5'd8, 32'h0000_3004, 32'h1000_0018);
    settle();
    chk("fl_allowin", allowin, 1'b1);
    chk("fl_empty", wb_valid, 1'b0);
    tick();
    ex_valid = 1'b0; data_ok = 1'b1; rdata = 32'h0000_DEAD; settle();
    chk("fl_stale_valid", wb_valid, 1'b0);
    chk("fl_stale_stall", fwd_stall, 1'b1);
    tick();
    rdata = 32'h0000_BEEF; settle();
    chk("fl_lw_valid", wb_valid, 1'b1);
    chk("fl_lw_result", wb_bus[63:32], 32'h0000_BEEF);
    chk("fl_lw_dest", wb_bus[68:64], 5'd8);
    tick();
    data_ok = 1'b0;

    // Flush coinciding with data_ok: no discard armed
    ex_valid = 1'b1; ex_bus = bus32(1'b1, 1'b1, LD_W, 1'b1, 5'd9, 32'h0000_4000, 32'h1000_001C);
    tick();
    ex_valid = 1'b0; flush = 1'b1; data_ok = 1'b1; rdata = 32'h0000_0011; settle();
    chk("fd_valid", wb_valid, 1'b0);
    tick();
    flush = 1'b0; data_ok = 1'b0;
    ex_valid = 1'b1; ex_bus = bus32(1'b1, 1'b1, LD_W, 1'b1, 5'd10, 32'h0000_4004, 32'h1000_0020);
    tick();
    ex_valid = 1'b0; data_ok = 1'b1; rdata = 32'h0000_0022; settle();
    chk("fd_next_valid", wb_valid, 1'b1);
    chk("fd_next_result", wb_bus[63:32], 32'h0000_0022);
    tick();
    data_ok = 1'b0;

    // Reset mid-WAIT
    ex_valid = 1'b1; ex_bus = bus32(1'b1, 1'b1, LD_W, 1'b1, 5'd11, 32'h0000_5000, 32'h1000_0024);
    tick();
    ex_valid = 1'b0; settle();
    chk("rw_stall", fwd_stall, 1'b1);
    reset = 1'b1;
    tick();
    reset = 1'b0; settle();
    chk("rw_allowin", allowin, 1'b1);
    chk("rw_valid", wb_valid, 1'b0);
    chk("rw_stall_clr", fwd_stall, 1'b0);
    chk("rw_fwd_we", fwd_we, 1'b0);
    data_ok = 1'b1; rdata = 32'h0000_0055; settle();
    chk("rw_late_ok", wb_valid, 1'b0);
    tick();
    data_ok = 1'b0;

    // 64-bit: LWU, LD, LW at offset 4, issued back to back
    ex64_valid = 1'b1; ex64_bus = bus64(LD_WU, 5'd3, 64'h0000_0000_0000_6004, 64'h2000);
    tick();
    ex64_bus = bus64(LD_D, 5'd4, 64'h0000_0000_0000_6004, 64'h2004);
    data_ok64 = 1'b1; rdata64 = 64'h8000_0001_0000_0000; settle();
    chk("lwu_valid", wb_valid64, 1'b1);
    chk("lwu_result", wb64_bus[127:64], 64'h0000_0000_8000_0001);
    tick();
    ex64_bus = bus64(LD_W, 5'd5, 64'h0000_0000_0000_6004, 64'h2008); settle();
    chk("ld_valid", wb_valid64, 1'b1);
    chk("ld_result", wb64_bus[127:64], 64'h8000_0001_0000_0000);
    tick();
    ex64_valid = 1'b0; settle();
    chk("lw64_result", wb64_bus[127:64], 64'hFFFF_FFFF_8000_0001);
    tick();
    data_ok64 = 1'b0; settle();
    chk("d64_drained", wb_valid64, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
